sipo_mem: RTL and testbench

SIPO_MEM -- requirements
Module: sipo_mem

---
 rtl/sipo_mem.sv | 130 +++++++++++++
 tb/tb_sipo_mem.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_mem.sv
// sipo_mem: serial-in / parallel-out frame buffer.
// Accepts one W-bit coefficient per handshake until a 128-entry frame is
// captured, then presents it as 16 rows of 8 lanes under a valid/ready
// handshake. Storage is 8 banks of ROWS x W, one bank per output lane.
module sipo_mem #(
    parameter int unsigned W     = 12,
    parameter int unsigned LANES = 8,
    parameter int unsigned ROWS  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [W-1:0]            din,
    output logic                    in_ready,
    input  logic                    out_ready,
    output logic [W-1:0]            a0,
    output logic [W-1:0]            a1,
    output logic [W-1:0]            a2,
    output logic [W-1:0]            a3,
    output logic [W-1:0]            a4,
    output logic [W-1:0]            a5,
    output logic [W-1:0]            a6,
    output logic [W-1:0]            a7,
    output logic                    out_valid,
    output logic                    full,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    done
);

    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned RW = $clog2(ROWS);

    localparam logic StFill  = 1'b0;
    localparam logic StDrain = 1'b1;

    logic          state_q, state_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [LW-1:0] wr_lane_q, wr_lane_d;
    logic [RW-1:0] rd_row_q, rd_row_d;

    logic wr_en, rd_xfer, last_wr, last_rd;

    // Bank j holds lane j; not reset, contents are only read after a full frame.
    logic [W-1:0] mem_q [LANES][ROWS];
    logic [W-1:0] lane_data [LANES];

    // Handshake decode.
    always_comb begin
        wr_en   = (state_q == StFill) && in_valid;
        rd_xfer = (state_q == StDrain) && out_ready;
        last_wr = wr_en && (wr_lane_q == LW'(LANES - 1)) && (wr_row_q == RW'(ROWS - 1));
        last_rd = rd_xfer && (rd_row_q == RW'(ROWS - 1));
    end

    // Next-state for the FSM and the write/read counters.
    always_comb begin
        state_d   = state_q;
        wr_row_d  = wr_row_q;
        wr_lane_d = wr_lane_q;
        rd_row_d  = rd_row_q;
        if (wr_en) begin
            if (wr_lane_q == LW'(LANES - 1)) begin
                wr_lane_d = '0;
                wr_row_d  = wr_row_q + 1'b1;
            end else begin
                wr_lane_d = wr_lane_q + 1'b1;
            end
            if (last_wr) begin
                // Write pointers are already cleared for the next frame.
                wr_row_d  = '0;
                wr_lane_d = '0;
                rd_row_d  = '0;
                state_d   = StDrain;
            end
        end
        if (rd_xfer) begin
            if (last_rd) begin
                rd_row_d = '0;
                state_d  = StFill;
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFill;
            wr_row_q  <= '0;
            wr_lane_q <= '0;
            rd_row_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_row_q  <= wr_row_d;
            wr_lane_q <= wr_lane_d;
            rd_row_q  <= rd_row_d;
        end
    end

    // Bank write: data is stored bit-exact, no arithmetic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_lane_q][wr_row_q] <= din;
        end
    end

    // Row read: lanes forced to zero outside DRAIN so reset shows an all-zero row.
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_data[j] = (state_q == StDrain) ? mem_q[j][rd_row_q] : '0;
        end
    end

    assign in_ready  = (state_q == StFill);
    assign out_valid = (state_q == StDrain);
    assign full      = (state_q == StDrain);
    assign row_idx   = rd_row_q;
    assign done      = last_rd;

    assign a0 = lane_data[0];
    assign a1 = lane_data[1];
    assign a2 = lane_data[2];
    assign a3 = lane_data[3];
    assign a4 = lane_data[4];
    assign a5 = lane_data[5];
    assign a6 = lane_data[6];
    assign a7 = lane_data[7];

endmodule

// File: tb/tb_sipo_mem.sv
// Directed self-checking bench for sipo_mem.
module tb_sipo_mem;

    localparam int W = 12;

    logic         clk, rst, in_valid, out_ready;
    logic [W-1:0] din;
    logic         in_ready, out_valid, full, done;
    logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [3:0]   row_idx;

    int vecs = 0;
    int errs = 0;

    // {in_ready, full, out_valid, done, row_idx, a7..a0}
    logic [8*W+7:0] obs;
    logic [8*W+7:0] obs_idle;

    assign obs      = {in_ready, full, out_valid, done, row_idx, a7, a6, a5, a4, a3, a2, a1, a0};
    assign obs_idle = {1'b1, {(8*W+7){1'b0}}};

    sipo_mem dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .a4        (a4),
        .a5        (a5),
        .a6        (a6),
        .a7        (a7),
        .out_valid (out_valid),
        .full      (full),
        .row_idx   (row_idx),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sample patterns: 0 -> k, 1 -> 0x800+k, 2 -> 127-k, 3 -> 0x200+k, 4 -> 0x300+k.
    function automatic logic [W-1:0] pat(input int mode, input int k);
        case (mode)
            0:       return W'(k);
            1:       return W'(32'h800 + k);
            2:       return W'(127 - k);
            3:       return W'(32'h200 + k);
            default: return W'(32'h300 + k);
        endcase
    endfunction

    // Expected observation for a DRAIN cycle showing row r.
    function automatic logic [8*W+7:0] mk_obs(input int mode, input int r, input bit rdy);
        logic [8*W-1:0] rowv;
        logic [3:0]     ri;
        for (int j = 0; j < 8; j++) rowv[j*W +: W] = pat(mode, 8*r + j);
        ri = r[3:0];
        return {1'b0, 1'b1, 1'b1, rdy && (r == 15), ri, rowv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: push a whole frame with no gaps.
    task automatic fill(input int mode);
        for (int k = 0; k < 128; k++) begin
            in_valid = 1'b1;
            din      = pat(mode, k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        tick();
        tick();
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL reset_state: got %h, expected %h", obs, obs_idle);
        end
        rst = 1'b1;
        tick();
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL reset_release_idle: got %h, expected %h", obs, obs_idle);
        end
    endtask

    task automatic test_continuous();
        out_ready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            in_valid = 1'b1;
            din      = pat(0, k);
            vecs++;
            if ({in_ready, full, out_valid} !== 3'b100) begin
                errs++;
                $display("FAIL cont_fill_k%0d: got %b, expected 100", k, {in_ready, full, out_valid});
            end
            tick();
        end
        in_valid = 1'b0;
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(0, r, 1'b1)) begin
                errs++;
                $display("FAIL cont_row%0d: got %h, expected %h", r, obs, mk_obs(0, r, 1'b1));
            end
            tick();
        end
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL cont_back_to_fill: got %h, expected %h", obs, obs_idle);
        end
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            in_valid = 1'b1;
            din      = pat(0, k);
            tick();
            if (k < 127) begin
                in_valid = 1'b0;
                din      = 12'hABC;
                vecs++;
                if ({in_ready, full} !== 2'b10) begin
                    errs++;
                    $display("FAIL gap_not_full_k%0d: got %b, expected 10", k, {in_ready, full});
                end
                tick();
            end
        end
        in_valid = 1'b0;
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(0, r, 1'b1)) begin
                errs++;
                $display("FAIL gap_row%0d: got %h, expected %h", r, obs, mk_obs(0, r, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        fill(0);
        // Junk offered throughout DRAIN must never be captured.
        in_valid = 1'b1;
        din      = 12'hFFF;
        for (int r = 0; r < 16; r++) begin
            if (r == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    vecs++;
                    if (obs !== mk_obs(0, 3, 1'b0) || a0 !== 12'd24) begin
                        errs++;
                        $display("FAIL bp_hold_s%0d: got %h, expected %h", s, obs, mk_obs(0, 3, 1'b0));
                    end
                    tick();
                end
                out_ready = 1'b1;
            end
            vecs++;
            if (obs !== mk_obs(0, r, 1'b1)) begin
                errs++;
                $display("FAIL bp_row%0d: got %h, expected %h", r, obs, mk_obs(0, r, 1'b1));
            end
            tick();
            if (r == 15) in_valid = 1'b0;
        end
        fill(3);
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(3, r, 1'b1)) begin
                errs++;
                $display("FAIL bp_clean_row%0d: got %h, expected %h", r, obs, mk_obs(3, r, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_reset_fill();
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            in_valid = 1'b1;
            din      = pat(4, k);
            tick();
        end
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL rst_fill_async: got %h, expected %h", obs, obs_idle);
        end
        tick();
        rst = 1'b1;
        tick();
        fill(1);
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(1, r, 1'b1)) begin
                errs++;
                $display("FAIL rst_fill_row%0d: got %h, expected %h", r, obs, mk_obs(1, r, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_reset_drain();
        out_ready = 1'b1;
        fill(0);
        for (int r = 0; r < 7; r++) begin
            vecs++;
            if (obs !== mk_obs(0, r, 1'b1)) begin
                errs++;
                $display("FAIL rst_drain_row%0d: got %h, expected %h", r, obs, mk_obs(0, r, 1'b1));
            end
            tick();
        end
        vecs++;
        if (row_idx !== 4'd7 || a0 !== 12'd56) begin
            errs++;
            $display("FAIL rst_drain_at7: got row_idx %0d a0 %0d, expected 7 56", row_idx, a0);
        end
        #3 rst = 1'b0;
        #1;
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL rst_drain_async: got %h, expected %h", obs, obs_idle);
        end
        tick();
        rst = 1'b1;
        tick();
        vecs++;
        if (obs !== obs_idle) begin
            errs++;
            $display("FAIL rst_drain_after: got %h, expected %h", obs, obs_idle);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fill(0);
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(0, r, 1'b1)) begin
                errs++;
                $display("FAIL b2b_f1_row%0d: got %h, expected %h", r, obs, mk_obs(0, r, 1'b1));
            end
            tick();
        end
        // Cycle right after done: first sample of the next frame is offered now.
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_ready_after_done: got %b, expected 1", in_ready);
        end
        fill(2);
        vecs++;
        if (a0 !== 12'd127 || a7 !== 12'd120) begin
            errs++;
            $display("FAIL b2b_f2_row0_ends: got a0 %0d a7 %0d, expected 127 120", a0, a7);
        end
        for (int r = 0; r < 16; r++) begin
            vecs++;
            if (obs !== mk_obs(2, r, 1'b1)) begin
                errs++;
                $display("FAIL b2b_f2_row%0d: got %h, expected %h", r, obs, mk_obs(2, r, 1'b1));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_backpressure();
        test_reset_fill();
        test_reset_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
